load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; all data and address paths are 32 bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port reqValid  input  1  core request present.
REQ-005 SHALL have port reqReady  output  1  request accepted on the same edge when reqValid=1.
REQ-006 SHALL have port reqWrite  input  1  1=store, 0=load.
REQ-007 SHALL have port reqSize  input  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 SHALL have port reqUnsigned  input  1  loads: 1=zero-extend, 0=sign-extend.
REQ-009 SHALL have port reqAddress  input  32  byte address.
REQ-010 SHALL have port reqData  input  32  store data, right-aligned.
REQ-011 SHALL have port respValid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port respData  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port respError  output  1  valid with respValid; misaligned or illegal request.
REQ-014 SHALL have ports memEnable, memWriteEnable  output  1 each; memAddress, memDataOut  output  32 each; memDataIn  input  32 -- drives the word RAM (one-cycle synchronous read, word index = memAddress[31:2]).

Function
REQ-015 SHALL implement states IDLE, ACCESS, CAPTURE, WRITE, RESP; reqReady = (state==IDLE), decoded from state.
REQ-016 SHALL, on acceptance in IDLE, latch address, data, size, write and unsigned fields; later reqX changes are ignored until the next acceptance.
REQ-017 SHALL treat as misaligned: half with addr[0]=1, word with addr[1:0]!=0, any reqSize=11.
REQ-018 SHALL drive memAddress = {addr[31:2],2'b00} and memEnable=1 only in ACCESS and WRITE; memEnable=0 and memWriteEnable=0 in all other states.
REQ-019 SHALL, for a load: IDLE->ACCESS->CAPTURE->RESP->IDLE; respValid high in the 3rd cycle after acceptance.
REQ-020 SHALL, in CAPTURE for loads, extract byte lane addr[1:0] or half lane addr[1] from memDataIn and sign- or zero-extend per reqUnsigned; word loads pass through unchanged.
REQ-021 SHALL, for a word store: IDLE->ACCESS(memWriteEnable=1, memDataOut=data)->RESP; respValid in the 2nd cycle.
REQ-022 SHALL, for byte/half stores (read-modify-write): IDLE->ACCESS(read)->CAPTURE(merge)->WRITE(memWriteEnable=1)->RESP; respValid in the 4th cycle.
REQ-023 SHALL merge by replacing only the addressed lane with reqData[7:0] or reqData[15:0]; other lanes keep memDataIn.
REQ-024 SHALL hold respValid=1 for exactly one cycle in RESP, then return to IDLE; no request is accepted in RESP.
REQ-025 SHALL hold memAddress and memDataOut at their last driven value outside ACCESS/WRITE.

Reset
REQ-026 SHALL, while resetN=0, force state IDLE and zero respValid, respData, respError, memEnable, memWriteEnable, memAddress and memDataOut; reqReady reads 1.
REQ-027 SHALL, on reset mid-operation, abandon the transaction with no response; if the RMW has not yet reached WRITE, no memory write occurs.

Configuration
REQ-028 SHALL, with LSU_ERROR_EN defined, send misaligned requests IDLE->RESP with respError=1, respData=0 and no memory access (respValid in the 1st cycle).
REQ-029 SHALL, without LSU_ERROR_EN, clear the offending low address bits (natural alignment), treat reqSize=11 as word, proceed normally, and tie respError to 0.

Verification
REQ-030 SHALL cover: word 0x100=0x8899AABB; signed byte load @0x101 -> respData=0xFFFFFFAA, respValid in cycle 3, memEnable high exactly 1 cycle.
REQ-031 SHALL cover: same word; unsigned half load @0x102 -> respData=0x00008899.
REQ-032 SHALL cover: store byte 0x5C @0x103 over 0x8899AABB -> memDataOut=0x5C99AABB with memWriteEnable in cycle 3; respValid in cycle 4; readback matches.
REQ-033 SHALL cover: store word 0xDEADBEEF @0x200 -> write in cycle 1, respValid in cycle 2; a following word load returns 0xDEADBEEF.
REQ-034 SHALL cover: word load @0x102 -> with LSU_ERROR_EN respError=1 in cycle 1 and memEnable never high; without the macro, reads word 0x100, respError=0.
REQ-035 SHALL cover: resetN pulsed low during CAPTURE of a byte store -> no memWriteEnable, all outputs 0, reqReady=1, memory word unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte/half/word load-store unit driving a one-cycle word RAM;
//               sub-word stores go through a read-modify-write sequence.
//               Optional macro LSU_ERROR_EN reports misaligned requests as
//               errors instead of naturally aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit (
   input  logic        clk,
   input  logic        resetN,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [1:0]  reqSize,
   input  logic        reqUnsigned,
   input  logic [31:0] reqAddress,
   input  logic [31:0] reqData,
   output logic        respValid,
   output logic [31:0] respData,
   output logic        respError,
   output logic        memEnable,
   output logic        memWriteEnable,
   output logic [31:0] memAddress,
   output logic [31:0] memDataOut,
   input  logic [31:0] memDataIn
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACCESS  = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      RESP    = 3'd4
   } state_t;

   localparam logic [1:0] c_size_byte = 2'b00;
   localparam logic [1:0] c_size_half = 2'b01;
   localparam logic [1:0] c_size_word = 2'b10;
   localparam logic [1:0] c_size_ill  = 2'b11;

`ifdef LSU_ERROR_EN
   localparam logic c_error_en = 1'b1;
`else
   localparam logic c_error_en = 1'b0;
`endif

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [1:0]  size_q, size_d;
   logic        write_q, write_d;
   logic        unsigned_q, unsigned_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_data_q, resp_data_d;

   logic        misaligned;
   logic [1:0]  eff_size;
   logic [31:0] eff_addr;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_result;
   logic [31:0] merged;

   // Request decode: alignment check and the naturally aligned fallback
   always_comb begin
      misaligned = 1'b0;
      case (reqSize)
         c_size_byte: misaligned = 1'b0;
         c_size_half: misaligned = reqAddress[0];
         c_size_word: misaligned = |reqAddress[1:0];
         default:     misaligned = 1'b1;
      endcase

      eff_size = (reqSize == c_size_ill) ? c_size_word : reqSize;

      case (eff_size)
         c_size_half: eff_addr = {reqAddress[31:1], 1'b0};
         c_size_word: eff_addr = {reqAddress[31:2], 2'b00};
         default:     eff_addr = reqAddress;
      endcase
   end

   // Lane extraction for loads and lane replacement for sub-word stores
   always_comb begin
      case (addr_q[1:0])
         2'd0:    lane_byte = memDataIn[7:0];
         2'd1:    lane_byte = memDataIn[15:8];
         2'd2:    lane_byte = memDataIn[23:16];
         default: lane_byte = memDataIn[31:24];
      endcase
      lane_half = addr_q[1] ? memDataIn[31:16] : memDataIn[15:0];

      case (size_q)
         c_size_byte: load_result = {{24{~unsigned_q & lane_byte[7]}}, lane_byte};
         c_size_half: load_result = {{16{~unsigned_q & lane_half[15]}}, lane_half};
         default:     load_result = memDataIn;
      endcase

      merged = memDataIn;
      case (size_q)
         c_size_byte: begin
            case (addr_q[1:0])
               2'd0:    merged[7:0]   = data_q[7:0];
               2'd1:    merged[15:8]  = data_q[7:0];
               2'd2:    merged[23:16] = data_q[7:0];
               default: merged[31:24] = data_q[7:0];
            endcase
         end
         c_size_half: begin
            if (addr_q[1]) merged[31:16] = data_q[15:0];
            else           merged[15:0]  = data_q[15:0];
         end
         default: merged = data_q;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      size_d       = size_q;
      write_d      = write_q;
      unsigned_d   = unsigned_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_data_d  = 32'd0;

      case (state_q)
         IDLE: begin
            if (reqValid) begin
               addr_d     = eff_addr;
               data_d     = reqData;
               size_d     = eff_size;
               write_d    = reqWrite;
               unsigned_d = reqUnsigned;
               if (c_error_en && misaligned) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d    = ACCESS;
                  mem_en_d   = 1'b1;
                  mem_addr_d = {eff_addr[31:2], 2'b00};
                  // Word stores write straight away; everything else reads first
                  if (reqWrite && (eff_size == c_size_word)) begin
                     mem_we_d    = 1'b1;
                     mem_wdata_d = reqData;
                  end
               end
            end
         end
         ACCESS: begin
            if (write_q && (size_q == c_size_word)) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (write_q) begin
               state_d     = WRITE;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b1;
               mem_wdata_d = merged;
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_data_d  = load_result;
            end
         end
         WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         addr_q       <= 32'd0;
         data_q       <= 32'd0;
         size_q       <= 2'b00;
         write_q      <= 1'b0;
         unsigned_q   <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         size_q       <= size_d;
         write_q      <= write_d;
         unsigned_q   <= unsigned_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign reqReady       = (state_q == IDLE);
   assign respValid      = resp_valid_q;
   assign respData       = resp_data_q;
   assign respError      = resp_err_q;
   assign memEnable      = mem_en_q;
   assign memWriteEnable = mem_we_q;
   assign memAddress     = mem_addr_q;
   assign memDataOut     = mem_wdata_q;

endmodule
`default_nettype wire
